acqbuf_ctrl: RTL and testbench

Capture sequencer for the ADC acquisition buffer in the DSP clock domain. Arms on a config-register start pulse and waits for an immediate or external trigger. Applies a programmable post-trigger delay, then writes decimated ADC samples into the acqbuf BRAM write port until a programmed length is reached. Reports busy/done status and the written sample count back to cfgregs.

---
 rtl/acqbuf_pkg.sv | 15 +
 rtl/acqbuf_decim.sv | 30 +++
 rtl/acqbuf_ctrl.sv | 159 +++++++++++++++
 tb/tb_acqbuf_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acqbuf_pkg.sv
// Shared types and constants for the acquisition-buffer capture sequencer.
package acqbuf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    CAPTURE,
    DONE
  } acqbuf_state_t;

  localparam logic TRIG_IMMEDIATE = 1'b0;
  localparam logic TRIG_EXTERNAL  = 1'b1;

endpackage

// File: rtl/acqbuf_decim.sv
// Reloadable decimation down-counter: fire is high on a valid sample when the count is zero.
module acqbuf_decim #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] factor,
  output logic             fire
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;

  assign fire = sample_valid && (count == '0);

  // A cleared counter fires on the very first valid sample after arming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (sample_valid) begin
      count <= (count == '0) ? factor : count - ONE;
    end
  end

endmodule

// File: rtl/acqbuf_ctrl.sv
// ADC acquisition-buffer capture sequencer: arm, trigger, post-trigger delay, decimated BRAM writes.
// Optional ACQBUF_CTRL_TIMESTAMP_EN adds a free-running cycle counter and the trig_time output.
module acqbuf_ctrl
  import acqbuf_pkg::*;
#(
  parameter int DATAWIDTH  = 64,
  parameter int ADDRWIDTH  = 12,
  parameter int DECWIDTH   = 8,
  parameter int DELAYWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  trig_mode,
  input  logic                  trigger,
  input  logic [ADDRWIDTH-1:0]  nsamples,
  input  logic [DECWIDTH-1:0]   decimation,
  input  logic [DELAYWIDTH-1:0] delay,
  input  logic [DATAWIDTH-1:0]  adc_data,
  input  logic                  adc_valid,
  output logic [ADDRWIDTH-1:0]  bram_addr,
  output logic [DATAWIDTH-1:0]  bram_data,
  output logic                  bram_we,
  output logic                  busy,
  output logic                  done,
  output logic [ADDRWIDTH:0]    wr_count
`ifdef ACQBUF_CTRL_TIMESTAMP_EN
  ,
  output logic [31:0]           trig_time
`endif
);

  localparam logic [ADDRWIDTH:0]    FULL_DEPTH = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0]    CNT_ONE    = (ADDRWIDTH + 1)'(1);
  localparam logic [ADDRWIDTH-1:0]  PTR_ONE    = ADDRWIDTH'(1);
  localparam logic [DELAYWIDTH-1:0] DLY_ONE    = DELAYWIDTH'(1);

  acqbuf_state_t         state;
  logic                  cfg_mode;
  logic [ADDRWIDTH:0]    cfg_target;
  logic [DECWIDTH-1:0]   cfg_dec;
  logic [DELAYWIDTH-1:0] cfg_delay;
  logic [DELAYWIDTH-1:0] delay_cnt;
  logic [ADDRWIDTH-1:0]  wr_ptr;
  logic                  trig_prev;
  logic                  arm_accept;
  logic                  trig_rise;
  logic                  trig_fire;
  logic                  sample_valid;
  logic                  fire;
  logic [ADDRWIDTH:0]    next_count;

  assign arm_accept   = start && !abort && (state == IDLE || state == DONE);
  assign trig_rise    = trigger && !trig_prev;
  assign trig_fire    = !abort && (state == ARMED) &&
                        (cfg_mode == TRIG_IMMEDIATE || trig_rise);
  assign sample_valid = adc_valid && (state == CAPTURE);
  assign next_count   = wr_count + CNT_ONE;

  acqbuf_decim #(
    .WIDTH(DECWIDTH)
  ) u_decim (
    .clk          (clk),
    .reset        (reset),
    .clear        (arm_accept),
    .sample_valid (sample_valid),
    .factor       (cfg_dec),
    .fire         (fire)
  );

  // Abort takes priority over every transition and squashes a write that would issue this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cfg_mode   <= TRIG_IMMEDIATE;
      cfg_target <= '0;
      cfg_dec    <= '0;
      cfg_delay  <= '0;
      delay_cnt  <= '0;
      wr_ptr     <= '0;
      trig_prev  <= 1'b0;
      wr_count   <= '0;
      bram_addr  <= '0;
      bram_data  <= '0;
      bram_we    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      trig_prev <= trigger;
      bram_we   <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state      <= ARMED;
              busy       <= 1'b1;
              done       <= 1'b0;
              cfg_mode   <= trig_mode;
              cfg_target <= (nsamples == '0) ? FULL_DEPTH : {1'b0, nsamples};
              cfg_dec    <= decimation;
              cfg_delay  <= delay;
              delay_cnt  <= '0;
              wr_ptr     <= '0;
              wr_count   <= '0;
            end
          end
          ARMED: begin
            if (trig_fire) state <= DELAY;
          end
          DELAY: begin
            if (delay_cnt == cfg_delay) state <= CAPTURE;
            else delay_cnt <= delay_cnt + DLY_ONE;
          end
          CAPTURE: begin
            if (fire) begin
              bram_we   <= 1'b1;
              bram_addr <= wr_ptr;
              bram_data <= adc_data;
              wr_ptr    <= wr_ptr + PTR_ONE;
              wr_count  <= next_count;
              // The final write and the move to DONE land on the same edge.
              if (next_count == cfg_target) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ACQBUF_CTRL_TIMESTAMP_EN
  logic [31:0] cycle_cnt;

  // trig_time captures the counter value on the ARMED-to-DELAY edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      trig_time <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (trig_fire) trig_time <= cycle_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_acqbuf_ctrl.sv
// Randomized scoreboard bench for acqbuf_ctrl; build with ACQBUF_CTRL_TIMESTAMP_EN to cover trig_time.
module tb_acqbuf_ctrl;

  localparam int DW   = 64;
  localparam int AW   = 4;
  localparam int DECW = 8;
  localparam int DLYW = 16;
  localparam int MAXL = 700;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            abort;
  logic            trig_mode;
  logic            trigger;
  logic [AW-1:0]   nsamples;
  logic [DECW-1:0] decimation;
  logic [DLYW-1:0] delay;
  logic [DW-1:0]   adc_data;
  logic            adc_valid;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_data;
  logic            bram_we;
  logic            busy;
  logic            done;
  logic [AW:0]     wr_count;
`ifdef ACQBUF_CTRL_TIMESTAMP_EN
  logic [31:0]     trig_time;
`endif

  acqbuf_ctrl #(
    .DATAWIDTH  (DW),
    .ADDRWIDTH  (AW),
    .DECWIDTH   (DECW),
    .DELAYWIDTH (DLYW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .trig_mode  (trig_mode),
    .trigger    (trigger),
    .nsamples   (nsamples),
    .decimation (decimation),
    .delay      (delay),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .bram_addr  (bram_addr),
    .bram_data  (bram_data),
    .bram_we    (bram_we),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count)
`ifdef ACQBUF_CTRL_TIMESTAMP_EN
    ,
    .trig_time  (trig_time)
`endif
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  logic [31:0] ts_ref;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) ts_ref <= '0;
    else ts_ref <= ts_ref + 32'd1;
  end

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          sb_off = 1'b0;
  int          exp_count = 0;
  bit          exp_done = 1'b0;
  bit          exp_busy = 1'b0;
  logic [31:0] exp_tt = '0;

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Every bram_we must match the oldest predicted write in address, data and cycle.
  task automatic monitor_loop();
    wr_t w;
    forever begin
      @(negedge clk);
      if (!reset && !sb_off && bram_we) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unexpected_write addr=%0d data=%0h cyc=%0d", bram_addr, bram_data, cyc);
        end else begin
          w = exp_q.pop_front();
          if (bram_addr !== w.addr || bram_data !== w.data || cyc != w.cyc) begin
            n_fail++;
            $display("[TB] FAIL write got addr=%0d data=%0h cyc=%0d want addr=%0d data=%0h cyc=%0d",
                     bram_addr, bram_data, cyc, w.addr, w.data, w.cyc);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check_output({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    check_output({tag, "_busy"}, 64'(busy), 64'(exp_busy));
    check_output({tag, "_done"}, 64'(done), 64'(exp_done));
    check_output({tag, "_wr_count"}, 64'(wr_count), 64'(exp_count));
`ifdef ACQBUF_CTRL_TIMESTAMP_EN
    check_output({tag, "_trig_time"}, 64'(trig_time), 64'(exp_tt));
`endif
  endtask

  // Builds one capture's stimulus, predicts its writes from the capture rules, then drives it.
  // trig_kind: 0 random toggles, 1 high/low/rise-at-50 profile.
  // valid_kind: 0 always, 1 alternate cycles, 2 random with pct percent.
  task automatic apply_stimulus(input bit mode, input int nsamp, input int dec, input int dly,
                                input int trig_kind, input int valid_kind, input int pct,
                                input bit ramp, input int abort_after, input int start2,
                                input int len);
    bit            st[MAXL];
    bit            ab[MAXL];
    bit            tg[MAXL];
    bit            vl[MAXL];
    logic [DW-1:0] dt[MAXL];
    int            wcyc[$];
    logic [DW-1:0] wdat[$];
    logic [DW-1:0] vidx;
    int            fire_rel;
    int            target;
    int            k;
    int            ar;
    int            base;
    wr_t           w;

    vidx = '0;
    for (int i = 0; i < len; i++) begin
      st[i] = (i == 0) || (i == start2);
      ab[i] = 1'b0;
      if (trig_kind == 1) tg[i] = (i < 10) || (i >= 50);
      else if (i == 0) tg[i] = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 7) == 0) tg[i] = !tg[i-1];
      else tg[i] = tg[i-1];
      if (valid_kind == 0) vl[i] = 1'b1;
      else if (valid_kind == 1) vl[i] = (i % 2) == 1;
      else vl[i] = $urandom_range(0, 99) < pct;
      if (vl[i] && ramp) dt[i] = vidx;
      else dt[i] = {$urandom, $urandom};
      if (vl[i]) vidx = vidx + 64'd1;
    end

    fire_rel = -1;
    if (mode == 1'b0) fire_rel = 1;
    else begin
      for (int i = 1; i < len; i++) begin
        if (tg[i] && !tg[i-1]) begin
          fire_rel = i;
          break;
        end
      end
    end
    target = (nsamp == 0) ? (1 << AW) : nsamp;
    if (fire_rel >= 0) begin
      k = 0;
      for (int i = fire_rel + dly + 2; i < len && wcyc.size() < target; i++) begin
        if (vl[i]) begin
          if (k % (dec + 1) == 0) begin
            wcyc.push_back(i);
            wdat.push_back(dt[i]);
          end
          k++;
        end
      end
    end
    exp_done = (wcyc.size() == target);
    ar = -1;
    if (abort_after > 0 && wcyc.size() > abort_after) begin
      ar = wcyc[abort_after-1] + 1;
      ab[ar] = 1'b1;
      while (wcyc.size() > abort_after) begin
        void'(wcyc.pop_back());
        void'(wdat.pop_back());
      end
      exp_done = 1'b0;
    end
    exp_count = wcyc.size();
    exp_busy = !exp_done && (ar < 0);
    if (fire_rel >= 0) exp_tt = ts_ref + 32'(fire_rel);

    base = cyc + 1;
    for (int j = 0; j < wcyc.size(); j++) begin
      w.cyc = base + wcyc[j];
      w.addr = AW'(j);
      w.data = wdat[j];
      exp_q.push_back(w);
    end

    for (int i = 0; i < len; i++) begin
      start = st[i];
      abort = ab[i];
      trigger = tg[i];
      adc_valid = vl[i];
      adc_data = dt[i];
      if (i == 0) begin
        trig_mode = mode;
        nsamples = AW'(nsamp);
        decimation = DECW'(dec);
        delay = DLYW'(dly);
      end else begin
        trig_mode = 1'($urandom);
        nsamples = AW'($urandom);
        decimation = DECW'($urandom);
        delay = DLYW'($urandom);
      end
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    adc_valid = 1'b0;
    repeat (2) step();
  endtask

  task automatic cleanup(input string tag);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    exp_busy = 1'b0;
    exp_done = 1'b0;
    check_status({tag, "_abort"});
  endtask

  task automatic collision(input string tag);
    start = 1'b1;
    abort = 1'b1;
    trig_mode = 1'b0;
    nsamples = AW'(3);
    decimation = '0;
    delay = '0;
    adc_valid = 1'b1;
    adc_data = {$urandom, $urandom};
    step();
    start = 1'b0;
    abort = 1'b0;
    repeat (6) begin
      adc_data = {$urandom, $urandom};
      step();
    end
    adc_valid = 1'b0;
    repeat (2) step();
    exp_busy = 1'b0;
    exp_done = 1'b0;
    check_status(tag);
  endtask

  task automatic reset_mid_capture();
    sb_off = 1'b1;
    start = 1'b1;
    trig_mode = 1'b0;
    nsamples = AW'(15);
    decimation = '0;
    delay = '0;
    adc_valid = 1'b1;
    adc_data = 64'h1;
    step();
    start = 1'b0;
    repeat (7) step();
    #2 reset = 1'b1;
    #1;
    check_output("rst_mid_we", 64'(bram_we), 64'd0);
    check_output("rst_mid_addr", 64'(bram_addr), 64'd0);
    check_output("rst_mid_busy", 64'(busy), 64'd0);
    check_output("rst_mid_count", 64'(wr_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();
    check_output("rst_mid_idle_busy", 64'(busy), 64'd0);
    adc_valid = 1'b0;
    sb_off = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    trig_mode = 1'b0;
    trigger = 1'b0;
    nsamples = '0;
    decimation = '0;
    delay = '0;
    adc_data = '0;
    adc_valid = 1'b0;
    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_we", 64'(bram_we), 64'd0);
    check_output("rst_addr", 64'(bram_addr), 64'd0);
    check_output("rst_data", bram_data, 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_count", 64'(wr_count), 64'd0);
`ifdef ACQBUF_CTRL_TIMESTAMP_EN
    check_output("rst_trig_time", 64'(trig_time), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    step();

    $display("[TB] immediate capture, trigger at counter 1234");
    while (ts_ref < 32'd1233) step();
    apply_stimulus(1'b0, 8, 0, 0, 0, 0, 100, 1'b1, 0, -1, 30);
    check_status("immediate");
`ifdef ACQBUF_CTRL_TIMESTAMP_EN
    check_output("ts_1234", 64'(trig_time), 64'd1234);
`endif
    cleanup("immediate");

    $display("[TB] decimation with gaps, start while busy");
    apply_stimulus(1'b0, 4, 2, 0, 0, 1, 100, 1'b1, 0, 6, 40);
    check_status("decim");
    cleanup("decim");

    $display("[TB] external trigger with delay");
    trigger = 1'b1;
    repeat (3) step();
    apply_stimulus(1'b1, 5, 0, 10, 1, 2, 60, 1'b1, 0, -1, 120);
    check_status("ext_trig");
    cleanup("ext_trig");

    $display("[TB] full depth then start+abort collision");
    apply_stimulus(1'b0, 0, 0, 3, 0, 2, 70, 1'b1, 0, -1, 80);
    check_status("full_depth");
    collision("collision");

    $display("[TB] abort after three writes");
    apply_stimulus(1'b0, 10, 1, 2, 0, 0, 100, 1'b1, 3, -1, 40);
    check_status("abort3");
    cleanup("abort3");

    $display("[TB] randomized captures");
    for (int t = 0; t < 8; t++) begin
      apply_stimulus(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 4),
                     $urandom_range(0, 20), 0, 2, $urandom_range(30, 100), 1'b0,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, -1, 600);
      check_status($sformatf("rand%0d", t));
      cleanup($sformatf("rand%0d", t));
    end

    $display("[TB] reset during capture");
    reset_mid_capture();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
